ocl_csr_arbiter: RTL and testbench
==================================

Name: ocl_csr_arbiter

Overview:
- AXI4-Lite slave on the shell OCL port. Converts each read or write transaction into a single-outstanding request on the CL's internal CSR bus, which feeds the wiredancer control/status registers.
- Arbitrates round-robin between a pending read and a pending write.
- Bounds every CSR access with a timeout, so the host never hangs the PCIe BAR.
- Sits at the CL top level, in place of the OCL tie-offs.

Parameters:
- ADDR_W, 32, OCL address width; the full address is forwarded to csr_addr.
- TIMEOUT_CYC, 256, cycles without csr_ack before the access is aborted (must be >= 2).
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on timeout or csr_err.

Ports:
- clk_main_a0  in  1  block clock
- rst_main_n  in  1  asynchronous active-low reset
- sh_ocl_awaddr  in  ADDR_W  write address; sh_ocl_awvalid in 1; cl_ocl_awready out 1
- sh_ocl_wdata  in  32  write data; sh_ocl_wstrb in 4; sh_ocl_wvalid in 1; cl_ocl_wready out 1
- cl_ocl_bresp  out  2  write response; cl_ocl_bvalid out 1; sh_ocl_bready in 1
- sh_ocl_araddr  in  ADDR_W  read address; sh_ocl_arvalid in 1; cl_ocl_arready out 1
- cl_ocl_rdata  out  32  read data; cl_ocl_rresp out 2; cl_ocl_rvalid out 1; sh_ocl_rready in 1
- csr_req  out  1  one-cycle request strobe
- csr_we  out  1  1 = write
- csr_addr  out  ADDR_W  request address
- csr_wdata  out  32  write data
- csr_wstrb  out  4  byte enables (0 on reads)
- csr_ack  in  1  completion strobe
- csr_rdata  in  32  valid when csr_ack is high
- csr_err  in  1  qualifies csr_ack; 1 = slave error
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; FSM = IDLE; capture flags cleared; rr_last = READ, so the first contested grant goes to WRITE. Reset mid-transaction drops the transaction; no response is issued.
- Capture:
  - awready = !aw_held; wready = !w_held; arready = !ar_held.
  - On a handshake, register the payload and set the corresponding *_held flag. AW and W may arrive in either order or in the same cycle.
  - Flags clear when that transaction's response handshake completes. Each channel accepts at most one outstanding transaction.
- Arbitration in IDLE:
  - wr_pend = aw_held & w_held; rd_pend = ar_held.
  - Only one pending: grant it.
  - Both pending: grant the opposite of rr_last. rr_last updates on each grant.
- FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
  - REQ: csr_req = 1 for exactly one cycle, with csr_we/addr/wdata/wstrb driven from the held registers. Timer loads 0.
  - WAIT: timer increments each cycle.
    - csr_ack: go to RESP; resp = csr_err ? 2'b10 : 2'b00; rdata = csr_err ? ERR_RDATA : csr_rdata.
    - Timer == TIMEOUT_CYC-1 with no ack: go to RESP; resp = 2'b10; rdata = ERR_RDATA.
    - csr_ack in the same cycle as timeout expiry: the ack wins.
    - csr_ack outside WAIT is ignored.
  - RESP: hold bvalid (write) or rvalid (read) with stable payload until bready/rready, then return to IDLE.
- Latency: arvalid handshake to rvalid = 3 + ack delay cycles, when the grant is immediate and csr_ack arrives N cycles after csr_req (N >= 1).
- Timer width: clog2(TIMEOUT_CYC)+1 bits; it never wraps.

Decomposition:
- Package ocl_csr_pkg:
  - FSM state enum.
  - resp constants: OKAY = 2'b00, SLVERR = 2'b10.
  - grant enum: READ/WRITE.
- One natural sub-module, ocl_csr_rr2, a 2-way round-robin arbiter with a registered last-grant.
- Everything else stays in ocl_csr_arbiter.

Test Plan:
- Write 0x10 = 0x1234_5678, wstrb F; csr_ack 2 cycles after csr_req -> exactly one csr_req pulse with csr_we = 1 and matching fields; bresp = 00; bvalid held through 3 cycles of bready = 0.
- W beat 4 cycles before AW -> no csr_req until AW arrives; a single request is issued.
- Read 0x20; ack with csr_rdata = 0xCAFE_0001 after 1 cycle -> rdata = 0xCAFE_0001, rresp = 00, rvalid 4 cycles after the AR handshake.
- AR and AW+W presented in the same cycle from reset -> write granted first, read second. Repeat -> write granted before read again.
- Read with no csr_ack -> rvalid at exactly TIMEOUT_CYC cycles of WAIT; rresp = 10, rdata = DEAD_BEEF. A late csr_ack afterwards changes nothing.
- Deassert rst_main_n while in WAIT -> all outputs 0 asynchronously, FSM in IDLE, a new read completes normally.

Source files
------------

// File: rtl/ocl_csr_pkg.sv
// Shared types for the OCL-to-CSR bridge: FSM states, grant encoding and
// AXI response codes, plus the round-robin pick function.
package ocl_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } gnt_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A lone requester wins outright; a contest goes to whoever did not win last.
    function automatic gnt_t rr_pick(input logic req_rd, input logic req_wr, input gnt_t last);
        gnt_t pick;
        if (req_rd && req_wr) begin
            pick = (last == GNT_READ) ? GNT_WRITE : GNT_READ;
        end else if (req_wr) begin
            pick = GNT_WRITE;
        end else begin
            pick = GNT_READ;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ocl_csr_rr2.sv
// Two-way round-robin arbiter (read vs write) with a registered last-grant.
// The last-grant register resets to READ, so the first contest goes to WRITE.
module ocl_csr_rr2
    import ocl_csr_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_rd,
    input  logic i_req_wr,
    output logic o_gnt_valid,
    output gnt_t o_gnt
);

    gnt_t r_last;
    gnt_t w_pick;

    assign w_pick      = rr_pick(i_req_rd, i_req_wr, r_last);
    assign o_gnt_valid = i_en & (i_req_rd | i_req_wr);
    assign o_gnt       = w_pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= GNT_READ;
        end else if (o_gnt_valid) begin
            r_last <= w_pick;
        end
    end

endmodule

// File: rtl/ocl_csr_arbiter.sv
// AXI4-Lite OCL slave that turns each read/write into one single-outstanding
// CSR bus request, with read/write round-robin and a bounded wait for csr_ack.
module ocl_csr_arbiter
    import ocl_csr_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
)
(
    input  logic              clk_main_a0,
    input  logic              rst_main_n,

    input  logic [ADDR_W-1:0] sh_ocl_awaddr,
    input  logic              sh_ocl_awvalid,
    output logic              cl_ocl_awready,

    input  logic [31:0]       sh_ocl_wdata,
    input  logic [3:0]        sh_ocl_wstrb,
    input  logic              sh_ocl_wvalid,
    output logic              cl_ocl_wready,

    output logic [1:0]        cl_ocl_bresp,
    output logic              cl_ocl_bvalid,
    input  logic              sh_ocl_bready,

    input  logic [ADDR_W-1:0] sh_ocl_araddr,
    input  logic              sh_ocl_arvalid,
    output logic              cl_ocl_arready,

    output logic [31:0]       cl_ocl_rdata,
    output logic [1:0]        cl_ocl_rresp,
    output logic              cl_ocl_rvalid,
    input  logic              sh_ocl_rready,

    output logic              csr_req,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [31:0]       csr_wdata,
    output logic [3:0]        csr_wstrb,
    input  logic              csr_ack,
    input  logic [31:0]       csr_rdata,
    input  logic              csr_err,

    output logic              busy
);

    // Handshakes on all five channels follow AXI valid/ready: a beat transfers on
    // the rising edge where both are high; valid never waits on ready.

    localparam int                TMR_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t             r_state;
    gnt_t               r_gnt;
    logic               r_rdy_en;
    logic               r_aw_held;
    logic               r_w_held;
    logic               r_ar_held;
    logic [ADDR_W-1:0]  r_awaddr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [ADDR_W-1:0]  r_araddr;
    logic [TMR_W-1:0]   r_timer;
    logic [1:0]         r_resp;
    logic [31:0]        r_rdata;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic               w_b_hs;
    logic               w_r_hs;
    logic               w_idle;
    logic               w_gnt_valid;
    gnt_t               w_gnt;
    logic               w_is_wr;

    // Readies stay low until the first clock after reset so every output is 0 in reset.
    assign cl_ocl_awready = r_rdy_en & ~r_aw_held;
    assign cl_ocl_wready  = r_rdy_en & ~r_w_held;
    assign cl_ocl_arready = r_rdy_en & ~r_ar_held;

    assign w_aw_hs = sh_ocl_awvalid & cl_ocl_awready;
    assign w_w_hs  = sh_ocl_wvalid  & cl_ocl_wready;
    assign w_ar_hs = sh_ocl_arvalid & cl_ocl_arready;
    assign w_b_hs  = cl_ocl_bvalid  & sh_ocl_bready;
    assign w_r_hs  = cl_ocl_rvalid  & sh_ocl_rready;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_is_wr = (r_gnt == GNT_WRITE);

    ocl_csr_rr2 u_rr2 (
        .clk         (clk_main_a0),
        .rst_n       (rst_main_n),
        .i_en        (w_idle),
        .i_req_rd    (r_ar_held),
        .i_req_wr    (r_aw_held & r_w_held),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt       (w_gnt)
    );

    assign busy          = ~w_idle;
    assign csr_req       = (r_state == ST_REQ);
    assign csr_we        = csr_req & w_is_wr;
    assign csr_addr      = csr_req ? (w_is_wr ? r_awaddr : r_araddr) : '0;
    assign csr_wdata     = csr_we ? r_wdata : 32'h0;
    assign csr_wstrb     = csr_we ? r_wstrb : 4'h0;

    assign cl_ocl_bvalid = (r_state == ST_RESP) & w_is_wr;
    assign cl_ocl_rvalid = (r_state == ST_RESP) & ~w_is_wr;
    assign cl_ocl_bresp  = cl_ocl_bvalid ? r_resp : 2'b00;
    assign cl_ocl_rresp  = cl_ocl_rvalid ? r_resp : 2'b00;
    assign cl_ocl_rdata  = cl_ocl_rvalid ? r_rdata : 32'h0;

    // Capture: one held transaction per channel, released by its response handshake.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_rdy_en  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_ar_held <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_araddr  <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_aw_hs) begin
                r_awaddr  <= sh_ocl_awaddr;
                r_aw_held <= 1'b1;
            end else if (w_b_hs) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_hs) begin
                r_wdata  <= sh_ocl_wdata;
                r_wstrb  <= sh_ocl_wstrb;
                r_w_held <= 1'b1;
            end else if (w_b_hs) begin
                r_w_held <= 1'b0;
            end
            if (w_ar_hs) begin
                r_araddr  <= sh_ocl_araddr;
                r_ar_held <= 1'b1;
            end else if (w_r_hs) begin
                r_ar_held <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= GNT_READ;
            r_timer <= '0;
            r_resp  <= RESP_OKAY;
            r_rdata <= 32'h0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt   <= w_gnt;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack on the expiry cycle still wins over the timeout.
                    if (csr_ack) begin
                        r_resp  <= csr_err ? RESP_SLVERR : RESP_OKAY;
                        r_rdata <= csr_err ? ERR_RDATA : csr_rdata;
                        r_state <= ST_RESP;
                    end else if (r_timer == TMR_LAST) begin
                        r_resp  <= RESP_SLVERR;
                        r_rdata <= ERR_RDATA;
                        r_state <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_b_hs || w_r_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ocl_csr_arbiter.sv
// Directed bench for ocl_csr_arbiter: AXI-Lite stimulus from one initial block,
// a CSR-request monitor fed by an expected queue, and immediate-assert checks.
module tb_ocl_csr_arbiter;

  localparam int          ADDR_W = 32;
  localparam int          TO     = 16;
  localparam logic [31:0] ERRD   = 32'hDEAD_BEEF;

  logic              clk_main_a0;
  logic              rst_main_n;
  logic [ADDR_W-1:0] sh_ocl_awaddr;
  logic              sh_ocl_awvalid;
  logic              cl_ocl_awready;
  logic [31:0]       sh_ocl_wdata;
  logic [3:0]        sh_ocl_wstrb;
  logic              sh_ocl_wvalid;
  logic              cl_ocl_wready;
  logic [1:0]        cl_ocl_bresp;
  logic              cl_ocl_bvalid;
  logic              sh_ocl_bready;
  logic [ADDR_W-1:0] sh_ocl_araddr;
  logic              sh_ocl_arvalid;
  logic              cl_ocl_arready;
  logic [31:0]       cl_ocl_rdata;
  logic [1:0]        cl_ocl_rresp;
  logic              cl_ocl_rvalid;
  logic              sh_ocl_rready;
  logic              csr_req;
  logic              csr_we;
  logic [ADDR_W-1:0] csr_addr;
  logic [31:0]       csr_wdata;
  logic [3:0]        csr_wstrb;
  logic              csr_ack;
  logic [31:0]       csr_rdata;
  logic              csr_err;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [68:0] exp_q[$];

  ocl_csr_arbiter #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TO),
    .ERR_RDATA   (ERRD)
  ) dut (
    .clk_main_a0    (clk_main_a0),
    .rst_main_n     (rst_main_n),
    .sh_ocl_awaddr  (sh_ocl_awaddr),
    .sh_ocl_awvalid (sh_ocl_awvalid),
    .cl_ocl_awready (cl_ocl_awready),
    .sh_ocl_wdata   (sh_ocl_wdata),
    .sh_ocl_wstrb   (sh_ocl_wstrb),
    .sh_ocl_wvalid  (sh_ocl_wvalid),
    .cl_ocl_wready  (cl_ocl_wready),
    .cl_ocl_bresp   (cl_ocl_bresp),
    .cl_ocl_bvalid  (cl_ocl_bvalid),
    .sh_ocl_bready  (sh_ocl_bready),
    .sh_ocl_araddr  (sh_ocl_araddr),
    .sh_ocl_arvalid (sh_ocl_arvalid),
    .cl_ocl_arready (cl_ocl_arready),
    .cl_ocl_rdata   (cl_ocl_rdata),
    .cl_ocl_rresp   (cl_ocl_rresp),
    .cl_ocl_rvalid  (cl_ocl_rvalid),
    .sh_ocl_rready  (sh_ocl_rready),
    .csr_req        (csr_req),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_wstrb      (csr_wstrb),
    .csr_ack        (csr_ack),
    .csr_rdata      (csr_rdata),
    .csr_err        (csr_err),
    .busy           (busy)
  );

  // clock / watchdog
  initial clk_main_a0 = 1'b0;
  always #5 clk_main_a0 = ~clk_main_a0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every csr_req pulse must match the next expected request
  always @(negedge clk_main_a0) begin
    if (csr_req === 1'b1) begin
      check("csr_req_expected", 69'(exp_q.size() != 0), 69'(1));
      if (exp_q.size() != 0) begin
        check("csr_req_fields", {csr_we, csr_addr, csr_wdata, csr_wstrb}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk_main_a0);
  endtask

  task automatic wait_for_req(input int budget);
    int n;
    n = 0;
    while (csr_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("req_seen", 69'(csr_req), 69'(1));
  endtask

  // Called on the negedge where csr_req is high; returns on the first RESP negedge.
  task automatic csr_respond(input int n, input logic [31:0] rd, input logic err);
    repeat (n) tick();
    csr_ack   = 1'b1;
    csr_rdata = rd;
    csr_err   = err;
    tick();
    csr_ack   = 1'b0;
    csr_rdata = 32'h0;
    csr_err   = 1'b0;
  endtask

  task automatic complete_b();
    sh_ocl_bready = 1'b1;
    tick();
    sh_ocl_bready = 1'b0;
    check("b_done", 69'({cl_ocl_bvalid, busy}), 69'(0));
  endtask

  task automatic complete_r();
    sh_ocl_rready = 1'b1;
    tick();
    sh_ocl_rready = 1'b0;
    check("r_done", 69'({cl_ocl_rvalid, busy}), 69'(0));
  endtask

  task automatic send_aw(input logic [31:0] a);
    sh_ocl_awaddr  = a;
    sh_ocl_awvalid = 1'b1;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    sh_ocl_wdata  = d;
    sh_ocl_wstrb  = s;
    sh_ocl_wvalid = 1'b1;
  endtask

  task automatic send_ar(input logic [31:0] a);
    sh_ocl_araddr  = a;
    sh_ocl_arvalid = 1'b1;
  endtask

  task automatic drop_valids();
    sh_ocl_awvalid = 1'b0;
    sh_ocl_wvalid  = 1'b0;
    sh_ocl_arvalid = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_main_n     = 1'b0;
    sh_ocl_awaddr  = '0;
    sh_ocl_awvalid = 1'b0;
    sh_ocl_wdata   = 32'h0;
    sh_ocl_wstrb   = 4'h0;
    sh_ocl_wvalid  = 1'b0;
    sh_ocl_bready  = 1'b0;
    sh_ocl_araddr  = '0;
    sh_ocl_arvalid = 1'b0;
    sh_ocl_rready  = 1'b0;
    csr_ack        = 1'b0;
    csr_rdata      = 32'h0;
    csr_err        = 1'b0;

    // reset state
    tick(); tick();
    check("reset_ctl", 69'({cl_ocl_awready, cl_ocl_wready, cl_ocl_arready, cl_ocl_bvalid,
                            cl_ocl_rvalid, csr_req, csr_we, busy}), 69'(0));
    check("reset_data", 69'({csr_addr, cl_ocl_rdata, cl_ocl_bresp, cl_ocl_rresp}), 69'(0));
    rst_main_n = 1'b1;
    tick();
    check("ready_after_reset", 69'({cl_ocl_awready, cl_ocl_wready, cl_ocl_arready}), 69'(3'b111));

    // write 0x10 = 0x12345678, ack two cycles after the request, bready held low
    exp_q.push_back({1'b1, 32'h10, 32'h1234_5678, 4'hF});
    send_aw(32'h10);
    send_w(32'h1234_5678, 4'hF);
    tick();
    drop_valids();
    check("t1_ready_low", 69'({cl_ocl_awready, cl_ocl_wready}), 69'(0));
    wait_for_req(8);
    csr_respond(2, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t1_bhold", 69'({cl_ocl_bvalid, cl_ocl_bresp, cl_ocl_rvalid}), 69'(4'b1000));
      tick();
    end
    complete_b();
    check("t1_ready_back", 69'({cl_ocl_awready, cl_ocl_wready}), 69'(2'b11));

    // W four cycles ahead of AW; slave error on the ack
    send_w(32'hA5A5_0003, 4'h3);
    tick();
    drop_valids();
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (csr_req === 1'b1) seen = 1'b1;
      tick();
    end
    check("t2_no_req_before_aw", 69'(seen), 69'(0));
    exp_q.push_back({1'b1, 32'h14, 32'hA5A5_0003, 4'h3});
    send_aw(32'h14);
    tick();
    drop_valids();
    wait_for_req(8);
    csr_respond(1, 32'h0, 1'b1);
    check("t2_bresp_err", 69'({cl_ocl_bvalid, cl_ocl_bresp}), 69'(3'b110));
    complete_b();

    // read 0x20, ack after one cycle: rvalid four cycles after the AR handshake
    exp_q.push_back({1'b0, 32'h20, 32'h0, 4'h0});
    send_ar(32'h20);
    tick();
    drop_valids();
    check("t3_c1", 69'({cl_ocl_arready, csr_req}), 69'(0));
    tick();
    check("t3_c2_req", 69'({csr_req, csr_we, csr_wstrb}), 69'(6'b100000));
    tick();
    csr_ack   = 1'b1;
    csr_rdata = 32'hCAFE_0001;
    check("t3_c3_no_rvalid", 69'(cl_ocl_rvalid), 69'(0));
    tick();
    csr_ack   = 1'b0;
    csr_rdata = 32'h0;
    check("t3_c4_rdata", 69'({cl_ocl_rvalid, cl_ocl_rresp, cl_ocl_rdata}), 69'({1'b1, 2'b00, 32'hCAFE_0001}));
    complete_r();

    // contested grants from reset: write first, then read, twice
    rst_main_n = 1'b0;
    tick();
    rst_main_n = 1'b1;
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      exp_q.push_back({1'b1, 32'h30, 32'h0000_00A0 + 32'(rep), 4'hF});
      exp_q.push_back({1'b0, 32'h34, 32'h0, 4'h0});
      send_aw(32'h30);
      send_w(32'h0000_00A0 + 32'(rep), 4'hF);
      send_ar(32'h34);
      tick();
      drop_valids();
      wait_for_req(8);
      check("t4_first_is_write", 69'(csr_we), 69'(1));
      csr_respond(1, 32'h0, 1'b0);
      check("t4_b_first", 69'({cl_ocl_bvalid, cl_ocl_rvalid, cl_ocl_bresp}), 69'(4'b1000));
      complete_b();
      wait_for_req(8);
      check("t4_second_is_read", 69'(csr_we), 69'(0));
      csr_respond(1, 32'h5555_0000 + 32'(rep), 1'b0);
      check("t4_r_second", 69'({cl_ocl_rvalid, cl_ocl_bvalid, cl_ocl_rdata}),
            69'({2'b10, 32'h5555_0000 + 32'(rep)}));
      complete_r();
    end

    // read with no ack: SLVERR/DEAD_BEEF after TO cycles of WAIT; late ack ignored
    exp_q.push_back({1'b0, 32'h40, 32'h0, 4'h0});
    send_ar(32'h40);
    tick();
    drop_valids();
    wait_for_req(8);
    seen = 1'b0;
    for (int k = 0; k < TO; k++) begin
      tick();
      if (cl_ocl_rvalid === 1'b1) seen = 1'b1;
    end
    check("t5_no_early_rvalid", 69'(seen), 69'(0));
    tick();
    check("t5_timeout_resp", 69'({cl_ocl_rvalid, cl_ocl_rresp, cl_ocl_rdata}), 69'({1'b1, 2'b10, ERRD}));
    csr_ack   = 1'b1;
    csr_rdata = 32'h1111_1111;
    tick();
    csr_ack   = 1'b0;
    csr_rdata = 32'h0;
    check("t5_late_ack_ignored", 69'({cl_ocl_rvalid, cl_ocl_rresp, cl_ocl_rdata}), 69'({1'b1, 2'b10, ERRD}));
    complete_r();

    // ack on the expiry cycle wins over the timeout
    exp_q.push_back({1'b0, 32'h44, 32'h0, 4'h0});
    send_ar(32'h44);
    tick();
    drop_valids();
    wait_for_req(8);
    csr_respond(TO, 32'hABCD_0002, 1'b0);
    check("t5b_ack_at_expiry", 69'({cl_ocl_rvalid, cl_ocl_rresp, cl_ocl_rdata}),
          69'({1'b1, 2'b00, 32'hABCD_0002}));
    complete_r();

    // asynchronous reset while in WAIT, then a clean read
    exp_q.push_back({1'b0, 32'h50, 32'h0, 4'h0});
    send_ar(32'h50);
    tick();
    drop_valids();
    wait_for_req(8);
    tick();
    check("t6_busy_in_wait", 69'(busy), 69'(1));
    #2;
    rst_main_n = 1'b0;
    #1;
    check("t6_async_reset", 69'({busy, cl_ocl_rvalid, cl_ocl_bvalid, cl_ocl_arready,
                                 cl_ocl_awready, cl_ocl_wready, csr_req, cl_ocl_rdata}), 69'(0));
    tick();
    rst_main_n = 1'b1;
    tick();
    check("t6_idle_after_reset", 69'({cl_ocl_arready, busy}), 69'(2'b10));
    exp_q.push_back({1'b0, 32'h54, 32'h0, 4'h0});
    send_ar(32'h54);
    tick();
    drop_valids();
    wait_for_req(8);
    csr_respond(3, 32'h600D_0006, 1'b0);
    check("t6_read_after_reset", 69'({cl_ocl_rvalid, cl_ocl_rresp, cl_ocl_rdata}),
          69'({1'b1, 2'b00, 32'h600D_0006}));
    complete_r();

    tick();
    check("exp_q_drained", 69'(exp_q.size()), 69'(0));

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
